dma_controller: RTL and testbench

// 4-channel AHB DMA controller. Software programs per-channel source, destination and control

---
 rtl/dma_controller_pkg.sv | 47 ++++
 rtl/dma_ch_regs.sv | 61 ++++++
 rtl/dma_controller.sv | 170 +++++++++++++++++
 tb/tb_dma_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_controller_pkg.sv
// Shared definitions for the 4-channel AHB DMA controller: register map,
// CTRL field positions, AHB encodings, per-channel config and the master FSM states.
package dma_controller_pkg;

   localparam int NUM_CH = 4;

   localparam logic [3:0][7:0] CTRL_OFF = {8'h36, 8'h24, 8'h12, 8'h00};
   localparam logic [3:0][7:0] SRC_OFF  = {8'h40, 8'h28, 8'h16, 8'h04};
   localparam logic [3:0][7:0] DST_OFF  = {8'h44, 8'h32, 8'h20, 8'h08};

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_TGT_BIT = 4;
   localparam int CTRL_CNT_LSB = 8;
   localparam int CTRL_CNT_MSB = 11;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D,
      ST_ACK
   } dma_state_e;

   typedef struct packed {
      logic        en;
      logic        tgt;
      logic [3:0]  cnt;
      logic [31:0] src;
      logic [31:0] dst;
   } ch_cfg_t;

   // Lowest-numbered eligible channel wins.
   function automatic logic [1:0] prio_pick(input logic [3:0] elig);
      prio_pick = 2'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (elig[i]) prio_pick = 2'(i);
      end
   endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// One DMA channel's CTRL/SRC/DST registers: software writes, post-transfer
// address/count update, error abort, and readback decode.
module dma_ch_regs
   import dma_controller_pkg::*;
#(
   parameter logic [7:0]  CTRL_ADDR = 8'h00,
   parameter logic [7:0]  SRC_ADDR  = 8'h04,
   parameter logic [7:0]  DST_ADDR  = 8'h08,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic        wr_en,
   input  logic [7:0]  reg_addr,
   input  logic [31:0] wr_data,
   input  logic        hw_ack,
   input  logic        hw_err,
   output ch_cfg_t     cfg,
   output logic [31:0] rd_data
);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         cfg <= '0;
      end else begin
         if (hw_ack) begin
            if (cfg.tgt) cfg.src <= cfg.src + ADDR_STEP;
            else         cfg.dst <= cfg.dst + ADDR_STEP;
            if (cfg.cnt != 4'd0) cfg.cnt <= cfg.cnt - 4'd1;
            if (cfg.cnt <= 4'd1) cfg.en  <= 1'b0;
         end
         if (hw_err) cfg.en <= 1'b0;
         // NOTE: nonblocking throughout; the software write comes last so it
         // overrides a hardware update to the same register in the same cycle.
         if (wr_en) begin
            case (reg_addr)
               CTRL_ADDR: begin
                  cfg.en  <= wr_data[CTRL_EN_BIT];
                  cfg.tgt <= wr_data[CTRL_TGT_BIT];
                  cfg.cnt <= wr_data[CTRL_CNT_MSB:CTRL_CNT_LSB];
               end
               SRC_ADDR: cfg.src <= wr_data;
               DST_ADDR: cfg.dst <= wr_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns rd_data and no latch is inferred.
      rd_data = '0;
      case (reg_addr)
         CTRL_ADDR: rd_data = {20'd0, cfg.cnt, 3'd0, cfg.tgt, 3'd0, cfg.en};
         SRC_ADDR:  rd_data = cfg.src;
         DST_ADDR:  rd_data = cfg.dst;
         default:   rd_data = '0;
      endcase
   end

endmodule

// File: rtl/dma_controller.sv
// 4-channel AHB DMA controller: AHB-Lite slave register port, fixed-priority
// arbiter and a single-word read-then-write AHB master FSM.
module dma_controller
   import dma_controller_pkg::*;
#(
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL_SLV,
   input  logic        HREADYIN_SLV,
   input  logic [1:0]  HTRANS_SLV,
   input  logic [2:0]  HSIZE_SLV,
   input  logic        HWRITE_SLV,
   input  logic [31:0] HADDR_SLV,
   input  logic [31:0] HWDATA_SLV,
   output logic        HREADYOUT_SLV,
   output logic [1:0]  HRESP_SLV,
   output logic [31:0] HRDATA_SLV,
   output logic        HSEL,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   input  logic        HREADY_IN,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA,
   input  logic        req_0,
   input  logic        req_1,
   input  logic        req_2,
   input  logic        req_3,
   output logic        ack_0,
   output logic        ack_1,
   output logic        ack_2,
   output logic        ack_3
);

   logic        slv_wr_ph, slv_rd_ph;
   logic [7:0]  slv_addr;
   ch_cfg_t     cfg     [NUM_CH];
   logic [31:0] ch_rdata[NUM_CH];
   logic [3:0]  req, elig, hw_ack, hw_err, ack_q;
   logic [1:0]  pick, cur_ch;
   logic [31:0] cur_dst, rd_word;
   logic        bus_err;
   dma_state_e  state;

   logic unused_bits;
   assign unused_bits = ^{HSIZE_SLV, HADDR_SLV[31:8]};

   assign HREADYOUT_SLV = 1'b1;
   assign HRESP_SLV     = HRESP_OKAY;
   assign HSIZE         = HSIZE_WORD;
   assign req           = {req_3, req_2, req_1, req_0};
   assign {ack_3, ack_2, ack_1, ack_0} = ack_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         slv_wr_ph <= 1'b0;
         slv_rd_ph <= 1'b0;
         slv_addr  <= '0;
      end else if (HREADYIN_SLV) begin
         slv_wr_ph <= HSEL_SLV & HTRANS_SLV[1] &  HWRITE_SLV;
         slv_rd_ph <= HSEL_SLV & HTRANS_SLV[1] & ~HWRITE_SLV;
         slv_addr  <= HADDR_SLV[7:0];
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      dma_ch_regs #(
         .CTRL_ADDR (CTRL_OFF[i]),
         .SRC_ADDR  (SRC_OFF[i]),
         .DST_ADDR  (DST_OFF[i]),
         .ADDR_STEP (32'(ADDR_STEP))
      ) u_regs (
         .hclk     (HCLK),
         .hreset_n (HRESETn),
         .wr_en    (slv_wr_ph),
         .reg_addr (slv_addr),
         .wr_data  (HWDATA_SLV),
         .hw_ack   (hw_ack[i]),
         .hw_err   (hw_err[i]),
         .cfg      (cfg[i]),
         .rd_data  (ch_rdata[i])
      );
   end

   always_comb begin
      HRDATA_SLV = '0;
      elig       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (slv_rd_ph) HRDATA_SLV = HRDATA_SLV | ch_rdata[i];
         elig[i] = cfg[i].en & (cfg[i].cnt != 4'd0) & req[i];
      end
   end

   assign pick    = prio_pick(elig);
   assign bus_err = ((state == ST_RD_D) || (state == ST_WR_D)) && (HRESP == HRESP_ERROR);

   always_comb begin
      hw_ack = '0;
      hw_err = '0;
      if (state == ST_ACK) hw_ack[cur_ch] = 1'b1;
      if (bus_err)         hw_err[cur_ch] = 1'b1;
   end

   // Destination is captured with the source at grant so mid-transfer register writes cannot disturb it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         cur_ch  <= '0;
         cur_dst <= '0;
         rd_word <= '0;
         HSEL    <= 1'b0;
         HTRANS  <= HTRANS_IDLE;
         HWRITE  <= 1'b0;
         HADDR   <= '0;
         HWDATA  <= '0;
         ack_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|elig) begin
               cur_ch  <= pick;
               cur_dst <= cfg[pick].dst;
               HADDR   <= cfg[pick].src;
               HTRANS  <= HTRANS_NONSEQ;
               HWRITE  <= 1'b0;
               HSEL    <= 1'b1;
               state   <= ST_RD_A;
            end
            ST_RD_A: begin
               HTRANS <= HTRANS_IDLE;
               state  <= ST_RD_D;
            end
            ST_RD_D: if (bus_err) begin
               HSEL  <= 1'b0;
               state <= ST_IDLE;
            end else if (HREADY_IN) begin
               rd_word <= HRDATA;
               HADDR   <= cur_dst;
               HWRITE  <= 1'b1;
               HTRANS  <= HTRANS_NONSEQ;
               state   <= ST_WR_A;
            end
            ST_WR_A: begin
               HTRANS <= HTRANS_IDLE;
               HWDATA <= rd_word;
               state  <= ST_WR_D;
            end
            ST_WR_D: if (bus_err) begin
               HSEL   <= 1'b0;
               HWRITE <= 1'b0;
               state  <= ST_IDLE;
            end else if (HREADY_IN) begin
               HSEL   <= 1'b0;
               HWRITE <= 1'b0;
               ack_q  <= 4'b0001 << cur_ch;
               state  <= ST_ACK;
            end
            ST_ACK: begin
               ack_q <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: register map, increment modes, priority,
// wait-state stretching, error abort and asynchronous reset mid-transfer.
module tb_dma_controller;

   localparam logic [31:0] RD_XOR = 32'hA5A5_0000;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL_SLV = 1'b0;
   logic        HREADYIN_SLV = 1'b1;
   logic [1:0]  HTRANS_SLV = 2'b00;
   logic [2:0]  HSIZE_SLV = 3'b010;
   logic        HWRITE_SLV = 1'b0;
   logic [31:0] HADDR_SLV = '0;
   logic [31:0] HWDATA_SLV = '0;
   logic        HREADYOUT_SLV;
   logic [1:0]  HRESP_SLV;
   logic [31:0] HRDATA_SLV;
   logic        HSEL;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HREADY_IN = 1'b1;
   logic [1:0]  HRESP = 2'b00;
   logic [31:0] HRDATA;
   logic        req_0 = 1'b0, req_1 = 1'b0, req_2 = 1'b0, req_3 = 1'b0;
   logic        ack_0, ack_1, ack_2, ack_3;
   logic [3:0]  acks;

   int n_cmp  = 0;
   int n_fail = 0;

   dma_controller dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HSEL_SLV      (HSEL_SLV),
      .HREADYIN_SLV  (HREADYIN_SLV),
      .HTRANS_SLV    (HTRANS_SLV),
      .HSIZE_SLV     (HSIZE_SLV),
      .HWRITE_SLV    (HWRITE_SLV),
      .HADDR_SLV     (HADDR_SLV),
      .HWDATA_SLV    (HWDATA_SLV),
      .HREADYOUT_SLV (HREADYOUT_SLV),
      .HRESP_SLV     (HRESP_SLV),
      .HRDATA_SLV    (HRDATA_SLV),
      .HSEL          (HSEL),
      .HTRANS        (HTRANS),
      .HSIZE         (HSIZE),
      .HWRITE        (HWRITE),
      .HADDR         (HADDR),
      .HWDATA        (HWDATA),
      .HREADY_IN     (HREADY_IN),
      .HRESP         (HRESP),
      .HRDATA        (HRDATA),
      .req_0         (req_0),
      .req_1         (req_1),
      .req_2         (req_2),
      .req_3         (req_3),
      .ack_0         (ack_0),
      .ack_1         (ack_1),
      .ack_2         (ack_2),
      .ack_3         (ack_3)
   );

   always #5 HCLK = ~HCLK;

   assign acks = {ack_3, ack_2, ack_1, ack_0};

   // Master-side memory model: read data is the address XOR a constant, and
   // deliberately wrong while HREADY_IN is low.
   logic        mdp_valid = 1'b0;
   logic        mdp_write = 1'b0;
   logic [31:0] mdp_addr  = '0;
   logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
   int          ack_cnt[4];

   assign HRDATA = (mdp_valid && !mdp_write && HREADY_IN) ? (mdp_addr ^ RD_XOR) : 32'hDEAD_BEEF;

   always @(posedge HCLK) begin
      if (HREADY_IN) begin
         if (mdp_valid && mdp_write) begin
            wr_addr_log.push_back(mdp_addr);
            wr_data_log.push_back(HWDATA);
         end
         if (mdp_valid && !mdp_write) rd_log.push_back(mdp_addr);
         mdp_valid <= HSEL && HTRANS[1];
         mdp_write <= HWRITE;
         mdp_addr  <= HADDR;
      end
      for (int i = 0; i < 4; i++) if (acks[i]) ack_cnt[i]++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      @(negedge HCLK);
      HSEL_SLV = 1'b1; HTRANS_SLV = 2'b10; HWRITE_SLV = 1'b1; HADDR_SLV = {24'd0, a};
      @(negedge HCLK);
      HSEL_SLV = 1'b0; HTRANS_SLV = 2'b00; HWRITE_SLV = 1'b0; HWDATA_SLV = d;
      @(negedge HCLK);
      HWDATA_SLV = '0;
   endtask

   task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
      @(negedge HCLK);
      HSEL_SLV = 1'b1; HTRANS_SLV = 2'b10; HWRITE_SLV = 1'b0; HADDR_SLV = {24'd0, a};
      @(negedge HCLK);
      HSEL_SLV = 1'b0; HTRANS_SLV = 2'b00;
      d = HRDATA_SLV;
   endtask

   task automatic set_req(input int ch, input logic v);
      case (ch)
         0: req_0 = v;
         1: req_1 = v;
         2: req_2 = v;
         default: req_3 = v;
      endcase
   endtask

   // Raises a request, waits (bounded) for its ack, drops it, then leaves one idle cycle.
   task automatic run_xfer(input int ch, output int lat);
      lat = -1;
      set_req(ch, 1'b1);
      for (int i = 1; i <= 40; i++) begin
         @(negedge HCLK);
         if (acks[ch]) begin
            lat = i;
            break;
         end
      end
      set_req(ch, 1'b0);
      @(negedge HCLK);
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
   endtask

   initial begin
      logic [31:0] rd;
      int          lat, base0, base3;

      // Reset state
      @(negedge HCLK);
      check("rst_acks", 32'(acks), 32'h0);
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_hsel", 32'(HSEL), 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      HRESETn = 1'b1;
      read_reg(8'h00, rd); check("rst_ctrl0", rd, 32'h0);
      read_reg(8'h04, rd); check("rst_src0", rd, 32'h0);
      read_reg(8'h08, rd); check("rst_dst0", rd, 32'h0);
      check("hreadyout", 32'(HREADYOUT_SLV), 32'h1);
      check("hresp_slv", 32'(HRESP_SLV), 32'h0);

      // TGT=0: fixed source, incrementing destination, 9 words
      write_reg(8'h04, 32'h4001_1000);
      write_reg(8'h08, 32'h4001_0000);
      write_reg(8'h00, 32'h0000_0901);
      clear_logs();
      base0 = ack_cnt[0];
      for (int k = 0; k < 9; k++) begin
         run_xfer(0, lat);
         check("t0_latency", 32'(lat), 32'd5);
      end
      check("t0_rd_count", 32'(rd_log.size()), 32'd9);
      check("t0_wr_count", 32'(wr_addr_log.size()), 32'd9);
      for (int k = 0; k < 9 && k < rd_log.size() && k < wr_addr_log.size(); k++) begin
         check("t0_rd_addr", rd_log[k], 32'h4001_1000);
         check("t0_wr_addr", wr_addr_log[k], 32'h4001_0000 + 32'(4 * k));
         check("t0_wr_data", wr_data_log[k], 32'h4001_1000 ^ RD_XOR);
      end
      check("t0_acks", 32'(ack_cnt[0] - base0), 32'd9);
      read_reg(8'h00, rd); check("t0_ctrl0_done", rd, 32'h0000_0000);
      read_reg(8'h08, rd); check("t0_dst0_final", rd, 32'h4001_0024);

      // TGT=1: incrementing source, fixed destination, 10 words, then an 11th request
      write_reg(8'h04, 32'h4001_0000);
      write_reg(8'h08, 32'h4001_1000);
      write_reg(8'h00, 32'h0000_0A11);
      clear_logs();
      for (int k = 0; k < 10; k++) begin
         run_xfer(0, lat);
         check("t1_latency", 32'(lat), 32'd5);
      end
      check("t1_rd_count", 32'(rd_log.size()), 32'd10);
      for (int k = 0; k < 10 && k < rd_log.size() && k < wr_addr_log.size(); k++) begin
         check("t1_rd_addr", rd_log[k], 32'h4001_0000 + 32'(4 * k));
         check("t1_wr_addr", wr_addr_log[k], 32'h4001_1000);
         check("t1_wr_data", wr_data_log[k], (32'h4001_0000 + 32'(4 * k)) ^ RD_XOR);
      end
      read_reg(8'h00, rd); check("t1_ctrl0_done", rd, 32'h0000_0010);
      read_reg(8'h04, rd); check("t1_src0_final", rd, 32'h4001_0028);
      run_xfer(0, lat);
      check("t1_11th_no_ack", 32'(lat), 32'hFFFF_FFFF);
      check("t1_11th_no_bus", 32'(rd_log.size()), 32'd10);

      // Register map: irregular offsets, unmapped offset, CTRL reserved bits
      write_reg(8'h16, 32'h1234_5678);
      read_reg(8'h16, rd); check("map_src1", rd, 32'h1234_5678);
      write_reg(8'h10, 32'hFFFF_FFFF);
      read_reg(8'h10, rd); check("map_unmapped", rd, 32'h0);
      write_reg(8'h24, 32'hFFFF_FFFE);
      read_reg(8'h24, rd); check("map_ctrl2_bits", rd, 32'h0000_0F10);
      write_reg(8'h24, 32'h0);

      // Priority: ch0 beats ch3 when both request together
      write_reg(8'h04, 32'h0000_1000);
      write_reg(8'h08, 32'h0000_2000);
      write_reg(8'h00, 32'h0000_0101);
      write_reg(8'h40, 32'h0000_3000);
      write_reg(8'h44, 32'h0000_4000);
      write_reg(8'h36, 32'h0000_0111);
      clear_logs();
      base0 = ack_cnt[0];
      base3 = ack_cnt[3];
      req_0 = 1'b1; req_3 = 1'b1;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge HCLK);
         if (|acks) begin lat = i; break; end
      end
      check("prio_first_ack", 32'(acks), 32'h1);
      check("prio_first_lat", 32'(lat), 32'd5);
      req_0 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge HCLK);
         if (ack_3) begin lat = i; break; end
      end
      check("prio_second_lat", 32'(lat), 32'd6);
      req_3 = 1'b0;
      repeat (3) @(negedge HCLK);
      check("prio_wr_count", 32'(wr_addr_log.size()), 32'd2);
      if (wr_addr_log.size() == 2 && rd_log.size() == 2) begin
         check("prio_rd0", rd_log[0], 32'h0000_1000);
         check("prio_wr0", wr_addr_log[0], 32'h0000_2000);
         check("prio_rd1", rd_log[1], 32'h0000_3000);
         check("prio_wr1", wr_addr_log[1], 32'h0000_4000);
      end
      check("prio_ack0_cnt", 32'(ack_cnt[0] - base0), 32'd1);
      check("prio_ack3_cnt", 32'(ack_cnt[3] - base3), 32'd1);
      read_reg(8'h36, rd); check("prio_ctrl3", rd, 32'h0000_0010);
      read_reg(8'h40, rd); check("prio_src3", rd, 32'h0000_3004);

      // HREADY_IN low for 3 cycles in the read data phase
      write_reg(8'h28, 32'h0000_9000);
      write_reg(8'h32, 32'h0000_A000);
      write_reg(8'h24, 32'h0000_0201);
      clear_logs();
      req_2 = 1'b1;
      @(negedge HCLK);
      @(negedge HCLK);
      HREADY_IN = 1'b0;
      @(negedge HCLK);
      check("stall_hsel", 32'(HSEL), 32'h1);
      check("stall_htrans", 32'(HTRANS), 32'h0);
      @(negedge HCLK);
      @(negedge HCLK);
      HREADY_IN = 1'b1;
      lat = -1;
      for (int i = 6; i <= 40; i++) begin
         @(negedge HCLK);
         if (ack_2) begin lat = i; break; end
      end
      req_2 = 1'b0;
      check("stall_latency", 32'(lat), 32'd8);
      @(negedge HCLK);
      check("stall_wr_count", 32'(wr_data_log.size()), 32'd1);
      if (wr_data_log.size() == 1) begin
         check("stall_wr_addr", wr_addr_log[0], 32'h0000_A000);
         check("stall_wr_data", wr_data_log[0], 32'h0000_9000 ^ RD_XOR);
      end

      // ERROR response in the write data phase
      write_reg(8'h04, 32'h0000_5000);
      write_reg(8'h08, 32'h0000_6000);
      write_reg(8'h00, 32'h0000_0301);
      base0 = ack_cnt[0];
      req_0 = 1'b1;
      repeat (4) @(negedge HCLK);
      check("err_wr_haddr", HADDR, 32'h0000_6000);
      check("err_wr_hwrite", 32'(HWRITE), 32'h1);
      check("err_wr_hwdata", HWDATA, 32'h0000_5000 ^ RD_XOR);
      HRESP = 2'b01;
      @(negedge HCLK);
      HRESP = 2'b00;
      check("err_hsel_dropped", 32'(HSEL), 32'h0);
      repeat (10) @(negedge HCLK);
      req_0 = 1'b0;
      check("err_no_ack", 32'(ack_cnt[0] - base0), 32'd0);
      read_reg(8'h00, rd); check("err_ctrl0", rd, 32'h0000_0300);

      // Asynchronous reset in the middle of a transfer
      write_reg(8'h16, 32'h0000_7000);
      write_reg(8'h20, 32'h0000_8000);
      write_reg(8'h12, 32'h0000_0201);
      req_1 = 1'b1;
      repeat (2) @(negedge HCLK);
      check("rstmid_busy", 32'(HSEL), 32'h1);
      HRESETn = 1'b0;
      #1;
      check("rstmid_hsel", 32'(HSEL), 32'h0);
      check("rstmid_htrans", 32'(HTRANS), 32'h0);
      check("rstmid_haddr", HADDR, 32'h0);
      check("rstmid_acks", 32'(acks), 32'h0);
      @(negedge HCLK);
      req_1 = 1'b0;
      HRESETn = 1'b1;
      read_reg(8'h12, rd); check("rstmid_ctrl1", rd, 32'h0);
      read_reg(8'h16, rd); check("rstmid_src1", rd, 32'h0);
      read_reg(8'h20, rd); check("rstmid_dst1", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
